// File: rtl/trace_capture.sv
// Trace buffer: lowest-index valid channel per cycle is recorded into a circular buffer,
// stops POST records after trig, then drains oldest-first. TRACE_TIMESTAMP_EN adds cycle stamps.
module trace_capture #(
    parameter int DATA_W = 77,
    parameter int CH     = 2,
    parameter int DEPTH  = 16,
    parameter int POST   = 8,
    parameter int CNT_W  = 32,
    localparam int CH_W  = (CH > 1) ? $clog2(CH) : 1,
`ifdef TRACE_TIMESTAMP_EN
    localparam int TS_EN = 1,
`else
    localparam int TS_EN = 0,
`endif
    localparam int REC_W = DATA_W + CH_W + TS_EN * CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CH-1:0]        ch_valid,
    input  logic [CH*DATA_W-1:0] ch_data,
    input  logic                 arm,
    input  logic                 trig,
    input  logic                 rd_req,
    output logic                 rd_valid,
    output logic [REC_W-1:0]     rd_data,
    output logic                 rd_empty,
    output logic [1:0]           state,
    output logic [15:0]          drop_cnt
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CW   = AW + 1;
    localparam int NV_W = $clog2(CH + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_POST  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     post_cnt, post_d;
    logic [AW-1:0]     wr_ptr;
    logic [CW-1:0]     count;
    logic [AW-1:0]     rd_addr;
    logic              wr_en;
    logic              sel_valid;
    logic [CH_W-1:0]   sel_id;
    logic [NV_W-1:0]   n_valid, n_drop;
    logic [16:0]       drop_sum;
    logic [DATA_W-1:0] sel_data;
    logic [REC_W-1:0]  wr_rec;
    logic [REC_W-1:0]  mem [DEPTH];

    always_comb begin
        sel_valid = 1'b0;
        sel_id    = '0;
        n_valid   = '0;
        for (int unsigned i = 0; i < CH; i++) begin
            if (ch_valid[i]) begin
                n_valid = n_valid + NV_W'(1);
                if (!sel_valid) begin
                    sel_valid = 1'b1;
                    sel_id    = CH_W'(i);
                end
            end
        end
    end

    assign sel_data = ch_data[int'(sel_id) * DATA_W +: DATA_W];
    assign n_drop   = sel_valid ? n_valid - NV_W'(1) : '0;
    assign drop_sum = {1'b0, drop_cnt} + 17'(n_drop);

`ifdef TRACE_TIMESTAMP_EN
    logic [CNT_W-1:0] cyc_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cyc_cnt <= '0;
        else     cyc_cnt <= cyc_cnt + CNT_W'(1);
    end

    assign wr_rec = {cyc_cnt, sel_id, sel_data};
`else
    assign wr_rec = {sel_id, sel_data};
`endif

    always_comb begin
        state_d = state_q;
        post_d  = post_cnt;
        wr_en   = 1'b0;
        if (arm) begin
            state_d = S_ARMED;
            post_d  = '0;
        end else begin
            case (state_q)
                S_ARMED: begin
                    wr_en = sel_valid;
                    if (trig) begin
                        state_d = S_POST;
                        post_d  = sel_valid ? CW'(1) : '0;
                        if (sel_valid && post_d == CW'(POST)) state_d = S_DONE;
                    end
                end
                S_POST: begin
                    wr_en = sel_valid;
                    if (sel_valid) begin
                        post_d = post_cnt + CW'(1);
                        if (post_d == CW'(POST)) state_d = S_DONE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            post_cnt <= '0;
        end else begin
            state_q  <= state_d;
            post_cnt <= post_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_rec;
    end

    // Writes stop in DONE, so the unread count doubles as the read pointer offset:
    // oldest unread entry is always wr_ptr - count.
    assign rd_addr = wr_ptr - count[AW-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            count    <= '0;
            drop_cnt <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else if (arm) begin
            wr_ptr   <= '0;
            count    <= '0;
            drop_cnt <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            if (wr_en) begin
                wr_ptr   <= wr_ptr + AW'(1);
                if (count != CW'(DEPTH)) count <= count + CW'(1);
                drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            end
            if (state_q == S_DONE && rd_req && count != '0) begin
                rd_valid <= 1'b1;
                rd_data  <= mem[rd_addr];
                count    <= count - CW'(1);
            end
        end
    end

    assign rd_empty = (state_q != S_DONE) || (count == '0);
    assign state    = state_q;

endmodule

// File: tb/tb_trace_capture.sv
// Scoreboard bench for trace_capture: stimulus pushes expected records, a monitor pops on rd_valid.
module tb_trace_capture;

    localparam int DATA_W = 77;
    localparam int CNT_W  = 32;
`ifdef TRACE_TIMESTAMP_EN
    localparam int REC_W = DATA_W + 1 + CNT_W;
`else
    localparam int REC_W = DATA_W + 1;
`endif

    logic                 tb_clk = 1'b0;
    logic                 rst;
    logic [1:0]           ch_valid;
    logic [2*DATA_W-1:0]  ch_data;
    logic                 arm, trig, rd_req;
    logic                 rd_valid;
    logic [REC_W-1:0]     rd_data;
    logic                 rd_empty;
    logic [1:0]           state;
    logic [15:0]          drop_cnt;

    int                   checks = 0;
    int                   errors = 0;
    int unsigned          cyc = 0;
    logic [REC_W-1:0]     exp_q[$];

    always #5 tb_clk = ~tb_clk;

    trace_capture #(
        .DATA_W(DATA_W),
        .CH(2),
        .DEPTH(16),
        .POST(8),
        .CNT_W(CNT_W)
    ) dut (
        .clk(tb_clk),
        .rst(rst),
        .ch_valid(ch_valid),
        .ch_data(ch_data),
        .arm(arm),
        .trig(trig),
        .rd_req(rd_req),
        .rd_valid(rd_valid),
        .rd_data(rd_data),
        .rd_empty(rd_empty),
        .state(state),
        .drop_cnt(drop_cnt)
    );

    function automatic logic [REC_W-1:0] mk_rec(input logic id, input int unsigned d, input int unsigned st);
        logic [CNT_W+1+DATA_W-1:0] full;
        full = {CNT_W'(st), id, DATA_W'(d)};
        return REC_W'(full);
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic monitor();
        logic [REC_W-1:0] e;
        forever begin
            @(negedge tb_clk);
            if (rd_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rd_valid", 128'(1), 128'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("rd_data", 128'(rd_data), 128'(e));
                end
            end
        end
    endtask

    task automatic drive(input logic [1:0] v, input int unsigned d0, input int unsigned d1,
                         input logic a, input logic t, input logic r);
        ch_valid = v;
        ch_data  = {DATA_W'(d1), DATA_W'(d0)};
        arm      = a;
        trig     = t;
        rd_req   = r;
    endtask

    task automatic tick();
        @(posedge tb_clk);
        #1;
        cyc++;
    endtask

    task automatic release_rst();
        @(posedge tb_clk);
        #1;
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic drain(input int n, input string tag);
        drive(2'b00, 0, 0, 1'b0, 1'b0, 1'b1);
        repeat (n) tick();
        drive(2'b00, 0, 0, 1'b0, 1'b0, 1'b0);
        @(negedge tb_clk);
        #1;
        chk({tag, "_rd_valid_idle"}, 128'(rd_valid), 128'(0));
        chk({tag, "_rd_empty"}, 128'(rd_empty), 128'(1));
        chk({tag, "_all_read"}, 128'(exp_q.size()), 128'(0));
        tick();
    endtask

    initial begin
        fork
            monitor();
        join_none

        rst = 1'b1;
        drive(2'b00, 0, 0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge tb_clk);
        #1;
        chk("rst_state", 128'(state), 128'(0));
        chk("rst_rd_valid", 128'(rd_valid), 128'(0));
        chk("rst_rd_data", 128'(rd_data), 128'(0));
        chk("rst_rd_empty", 128'(rd_empty), 128'(1));
        chk("rst_drop", 128'(drop_cnt), 128'(0));
        release_rst();

        // Basic window: arm at 2, ch0 data = cycle, trig at 30
        while (cyc < 38) begin
            drive(2'b01, cyc, 0, cyc == 2, cyc == 30, 1'b0);
            if (cyc == 30) chk("basic_armed_at_trig", 128'(state), 128'(1));
            if (cyc == 37) chk("basic_post_before_done", 128'(state), 128'(2));
            tick();
        end
        drive(2'b00, 0, 0, 1'b0, 1'b0, 1'b0);
        chk("basic_done_at_38", 128'(state), 128'(3));
        chk("basic_not_empty", 128'(rd_empty), 128'(0));
        chk("basic_drop", 128'(drop_cnt), 128'(0));
        for (int unsigned k = 22; k <= 37; k++) exp_q.push_back(mk_rec(1'b0, k, k));
        drain(18, "basic");

        // Underfill: 3 samples, trig without sample, 5 samples, then 3 more
        drive(2'b00, 0, 0, 1'b1, 1'b0, 1'b0);
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(2'b10, 0, cyc, 1'b0, 1'b0, 1'b0);
            exp_q.push_back(mk_rec(1'b1, cyc, cyc));
            tick();
        end
        drive(2'b00, 0, 0, 1'b0, 1'b1, 1'b0);
        tick();
        for (int k = 0; k < 5; k++) begin
            drive(2'b01, cyc, 0, 1'b0, 1'b1, 1'b0);
            exp_q.push_back(mk_rec(1'b0, cyc, cyc));
            tick();
            drive(2'b00, 0, 0, 1'b0, 1'b0, 1'b0);
            tick();
        end
        chk("under_stays_post", 128'(state), 128'(2));
        for (int k = 0; k < 3; k++) begin
            drive(2'b01, cyc, 0, 1'b0, 1'b0, 1'b0);
            exp_q.push_back(mk_rec(1'b0, cyc, cyc));
            tick();
        end
        drive(2'b00, 0, 0, 1'b0, 1'b0, 1'b0);
        chk("under_done", 128'(state), 128'(3));
        chk("under_not_empty", 128'(rd_empty), 128'(0));
        drain(12, "under");

        // Collision: ch0 and ch1 together for 5 cycles, trig on the 5th
        drive(2'b00, 0, 0, 1'b1, 1'b0, 1'b0);
        tick();
        for (int k = 0; k < 5; k++) begin
            drive(2'b11, cyc, cyc + 1000, 1'b0, k == 4, 1'b0);
            exp_q.push_back(mk_rec(1'b0, cyc, cyc));
            tick();
        end
        for (int k = 0; k < 7; k++) begin
            drive(2'b01, cyc, 0, 1'b0, 1'b0, 1'b0);
            exp_q.push_back(mk_rec(1'b0, cyc, cyc));
            tick();
        end
        drive(2'b00, 0, 0, 1'b0, 1'b0, 1'b0);
        chk("coll_done", 128'(state), 128'(3));
        chk("coll_drop", 128'(drop_cnt), 128'(5));
        drain(13, "coll");

        // Re-arm during POST discards the earlier records
        drive(2'b00, 0, 0, 1'b1, 1'b0, 1'b0);
        tick();
        for (int k = 0; k < 4; k++) begin
            drive(2'b01, cyc, 0, 1'b0, k == 2, 1'b0);
            tick();
        end
        chk("rearm_in_post", 128'(state), 128'(2));
        drive(2'b00, 0, 0, 1'b1, 1'b0, 1'b0);
        tick();
        chk("rearm_armed", 128'(state), 128'(1));
        for (int k = 0; k < 8; k++) begin
            drive(2'b01, cyc, 0, 1'b0, k == 0, 1'b0);
            exp_q.push_back(mk_rec(1'b0, cyc, cyc));
            tick();
        end
        drive(2'b00, 0, 0, 1'b0, 1'b0, 1'b0);
        chk("rearm_done", 128'(state), 128'(3));

        // Reset in the middle of a read burst
        drive(2'b00, 0, 0, 1'b0, 1'b0, 1'b1);
        tick();
        tick();
        chk("midread_valid", 128'(rd_valid), 128'(1));
        chk("midread_pending", 128'(exp_q.size()), 128'(7));
        exp_q.delete();
        rst = 1'b1;
        #1;
        chk("rst_async_state", 128'(state), 128'(0));
        chk("rst_async_rd_valid", 128'(rd_valid), 128'(0));
        chk("rst_async_empty", 128'(rd_empty), 128'(1));
        release_rst();

        // rd_req and trig in IDLE are ignored; arm with trig lands in ARMED
        drive(2'b01, 5, 0, 1'b0, 1'b1, 1'b1);
        repeat (3) tick();
        chk("idle_ignores", 128'(state), 128'(0));
        drive(2'b01, 5, 0, 1'b1, 1'b1, 1'b0);
        tick();
        drive(2'b00, 0, 0, 1'b0, 1'b0, 1'b0);
        chk("arm_wins_trig", 128'(state), 128'(1));
        tick();
        chk("armed_holds", 128'(state), 128'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/trace_capture.md
# trace_capture

Synthesizable on-chip trace buffer for the out-of-order core. It watches up to CH pipeline channels, for example the fetch instruction and the current LSQ entry, and stores cycle-stamped records in a circular buffer. Recording runs continuously while armed and stops a fixed number of records after a trigger. The captured window is then drained oldest-first through a read handshake, which gives the cycle-by-cycle pipeline view in hardware rather than only in simulation.

## Interface
- DATA_W, 77, payload width per channel (one LSQ entry).
- CH, 2, number of monitored channels, 1..16.
- DEPTH, 16, buffer entries; must be a power of 2, at least 2.
- POST, 8, records captured after the trigger, including the trigger-cycle record; 1..DEPTH.
- CNT_W, 32, cycle-stamp width.
- Derived widths:
  - CH_W = max(1, clog2(CH)).
  - REC_W = DATA_W + CH_W, plus CNT_W when TRACE_TIMESTAMP_EN is defined.
- Clock and reset: one clock; reset is asynchronous and active-high.

Ports:
- clk  in  1  clock; all state updates on the posedge.
- rst  in  1  asynchronous, active-high reset.
- ch_valid  in  CH  per-channel sample-valid.
- ch_data  in  CH*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W].
- arm  in  1  pulse; starts a new capture.
- trig  in  1  trigger; sampled only in state ARMED.
- rd_req  in  1  requests the next record; honoured only in state DONE.
- rd_valid  out  1  high for exactly one cycle, the cycle after an accepted rd_req.
- rd_data  out  REC_W  record, packed as {stamp (if enabled), ch_id, data}.
- rd_empty  out  1  in DONE, high when no unread records remain.
- state  out  2  IDLE=0, ARMED=1, POST=2, DONE=3.
- drop_cnt  out  16  count of lost same-cycle samples; saturates at 16'hFFFF.

## Operation
- Cycle counter:
  - free-running; increments every clk.
  - wraps modulo 2^CNT_W.
  - cleared only by rst.
- Record selection:
  - each cycle, the lowest-index channel with ch_valid high is recorded.
  - every other valid channel in that cycle adds 1 to drop_cnt, subject to saturation.
  - a cycle with no valid channel records nothing.
- IDLE:
  - no recording.
  - arm → ARMED; this clears wr_ptr, count and drop_cnt.
- ARMED:
  - writes are circular at wr_ptr.
  - count saturates at DEPTH; once full, the oldest entry is overwritten.
  - trig → POST; post_cnt = 0.
- POST:
  - each write increments post_cnt.
  - the trigger-cycle write (if any) counts as the first post record.
  - when post_cnt reaches POST → DONE.
  - trig is ignored.
- DONE:
  - no writes.
  - rd_ptr is initialised to wr_ptr − count (mod DEPTH); reads run oldest to newest.
  - rd_req with records remaining: next cycle rd_valid=1 with that record; rd_ptr advances and the remaining count decrements.
  - rd_req when empty: ignored; rd_valid stays 0.
- arm in ARMED, POST or DONE: restarts as from IDLE. Any in-flight capture or read is discarded.
- arm together with trig in IDLE: arm wins and trig is ignored. The next trig must arrive while in ARMED.
- rd_req outside DONE: ignored.

## Timing
- Reset values:
  - state=IDLE; rd_valid=0; rd_data=0; rd_empty=1.
  - drop_cnt=0; cycle counter=0; all pointers and counts 0.
  - buffer contents are don't-care.
- Write latency: a sample on cycle N is written at the posedge ending cycle N. Its stamp is the counter value during N.
- State transitions take effect on the next posedge. The write that completes POST occurs in that same edge.
- Read latency: 1 cycle (rd_req at N → rd_valid and rd_data at N+1). Back-to-back rd_req gives one record per cycle.
- rd_empty is combinational from the registered remaining count.
- rd_data holds its last value when rd_valid=0.
- rst mid-capture or mid-read: everything returns to reset values immediately (asynchronously).

## Configuration
- TRACE_TIMESTAMP_EN:
  - defined: each record carries a CNT_W-bit cycle stamp in its MSBs.
  - undefined: the stamp field and the cycle counter are removed, and REC_W = DATA_W + CH_W.
  - all other behaviour is identical.

## Test plan
- Basic window:
  - CH=2, DEPTH=16, POST=8. Arm at cycle 2; ch0 valid every cycle with data = cycle; trig at cycle 30.
  - Expect DONE at cycle 38.
  - 16 reads return ch0 data 22..37, with stamps equal to the data.
- Underfill:
  - arm, 3 samples, trig, POST=8, with only 5 more samples.
  - expect state stays POST.
  - 3 more samples → DONE; count = 11; reads return 11 records in order, then rd_empty=1.
- Collision:
  - ch0 and ch1 valid together for 5 cycles.
  - only ch_id=0 records are stored; drop_cnt=5.
- Read handshake:
  - rd_req held 18 cycles in DONE with 16 records.
  - 16 rd_valid pulses, then rd_valid=0 and rd_empty=1.
- Re-arm and reset:
  - arm during POST returns to ARMED with count=0.
  - rst asserted mid-read: state=IDLE and rd_valid=0 in the same cycle.
- Macro off:
  - build without TRACE_TIMESTAMP_EN: rd_data width = DATA_W+1 for CH=2; the basic-window data matches.
